// File: rtl/parking_pkg.sv
// Shared types and helpers for the parking entrance controller.
package parking_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        PIN   = 2'd1,
        OPEN  = 2'd2,
        BLOCK = 2'd3
    } park_state_e;

    // Counter width helper: never returns zero so single-value ranges stay legal.
    function automatic int clog2_w(input int value);
        return (value <= 1) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/parking_occupancy_counter.sv
// Up/down saturating car counter with registered full flag.
module parking_occupancy_counter
    import parking_pkg::*;
#(
    parameter int CAPACITY = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             inc,
    input  logic                             dec,
    output logic [$clog2(CAPACITY+1)-1:0]    occupancy,
    output logic                             full
);

    localparam int               OCC_W = clog2_w(CAPACITY + 1);
    localparam logic [OCC_W-1:0] CAP_V = OCC_W'(CAPACITY);

    logic [OCC_W-1:0] count_r;
    logic [OCC_W-1:0] count_s;
    logic             full_r;

    // Next count: simultaneous inc/dec cancel, both ends saturate.
    always_comb begin
        count_s = count_r;
        case ({inc, dec})
            2'b10: begin
                if (count_r != CAP_V) begin
                    count_s = count_r + OCC_W'(1);
                end else begin
                    count_s = count_r;
                end
            end
            2'b01: begin
                if (count_r != '0) begin
                    count_s = count_r - OCC_W'(1);
                end else begin
                    count_s = count_r;
                end
            end
            default: count_s = count_r;
        endcase
    end

    // Count and full flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= '0;
            full_r  <= 1'b0;
        end else begin
            count_r <= count_s;
            full_r  <= (count_s == CAP_V);
        end
    end

    assign occupancy = count_r;
    assign full      = full_r;

endmodule

// File: rtl/parking_access_ctrl_p.sv
// Parking entrance controller: PIN check, gate timing, tailgate alarm.
// Lot occupancy tracking is built only when PARK_OCCUPANCY_EN is defined.
module parking_access_ctrl_p
    import parking_pkg::*;
#(
    parameter int                PSWD_W       = 8,
    parameter logic [PSWD_W-1:0] PSWD         = 8'd87,
    parameter int                MAX_ATTEMPTS = 3,
    parameter int                GATE_TIMEOUT = 1000,
    parameter int                CAPACITY     = 16
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 sensor_1,
    input  logic                                 sensor_2,
    input  logic                                 try_psswrd,
    input  logic [PSWD_W-1:0]                    psswrd_atmpt,
    input  logic                                 car_exit,
    output logic                                 alarm_1,
    output logic                                 alarm_2,
    output logic                                 open_gate,
    output logic                                 close_gate,
    output logic                                 gate_timeout,
    output logic                                 lot_full,
    output logic [$clog2(CAPACITY+1)-1:0]        occupancy,
    output logic [$clog2(MAX_ATTEMPTS+1)-1:0]    fail_count
);

    localparam int               OCC_W    = clog2_w(CAPACITY + 1);
    localparam int               FC_W     = clog2_w(MAX_ATTEMPTS + 1);
    localparam int               TMR_W    = clog2_w(GATE_TIMEOUT);
    localparam logic [FC_W-1:0]  FC_MAX   = FC_W'(MAX_ATTEMPTS);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(GATE_TIMEOUT - 1);

    park_state_e      state_r, state_s;
    logic [TMR_W-1:0] timer_r;
    logic [FC_W-1:0]  fail_count_r, fail_count_s, fail_inc_s;
    logic             alarm_1_r, alarm_1_s;
    logic             alarm_2_r, alarm_2_s;
    logic             open_gate_r, open_gate_s;
    logic             close_gate_r, close_gate_s;
    logic             gate_timeout_r, gate_timeout_s;
    logic             car_entered_s;
    logic             tailgate_s, try_ok_s, try_bad_s, timeout_hit_s;
    logic             lot_full_s;
    logic [OCC_W-1:0] occupancy_s;

    assign tailgate_s    = sensor_1 && sensor_2;
    assign try_ok_s      = try_psswrd && (psswrd_atmpt == PSWD);
    assign try_bad_s     = try_psswrd && (psswrd_atmpt != PSWD);
    assign timeout_hit_s = (state_r == OPEN) && (timer_r == TMR_LAST);
    assign fail_inc_s    = (fail_count_r == FC_MAX) ? FC_MAX : (fail_count_r + FC_W'(1));

    // State register together with the registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= IDLE;
            fail_count_r   <= '0;
            alarm_1_r      <= 1'b0;
            alarm_2_r      <= 1'b0;
            open_gate_r    <= 1'b0;
            close_gate_r   <= 1'b0;
            gate_timeout_r <= 1'b0;
        end else begin
            state_r        <= state_s;
            fail_count_r   <= fail_count_s;
            alarm_1_r      <= alarm_1_s;
            alarm_2_r      <= alarm_2_s;
            open_gate_r    <= open_gate_s;
            close_gate_r   <= close_gate_s;
            gate_timeout_r <= gate_timeout_s;
        end
    end

    // Gate-open timer: zero on the first OPEN cycle, cleared elsewhere.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_r <= '0;
        end else if (state_r == OPEN) begin
            timer_r <= timer_r + TMR_W'(1);
        end else begin
            timer_r <= '0;
        end
    end

    // Next-state logic; a tailgate sighting outranks everything outside BLOCK.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (tailgate_s)                  state_s = BLOCK;
                else if (sensor_1 && !lot_full_s) state_s = PIN;
                else                             state_s = IDLE;
            end
            PIN: begin
                if (tailgate_s)    state_s = BLOCK;
                else if (try_ok_s) state_s = OPEN;
                else               state_s = PIN;
            end
            OPEN: begin
                if (tailgate_s)                     state_s = BLOCK;
                else if (sensor_2 || timeout_hit_s) state_s = IDLE;
                else                                state_s = OPEN;
            end
            BLOCK: begin
                if (try_ok_s) state_s = IDLE;
                else          state_s = BLOCK;
            end
            default: state_s = IDLE;
        endcase
    end

    // Output logic; close_gate and gate_timeout are single-cycle pulses.
    always_comb begin
        fail_count_s   = fail_count_r;
        alarm_1_s      = alarm_1_r;
        alarm_2_s      = alarm_2_r;
        open_gate_s    = open_gate_r;
        close_gate_s   = 1'b0;
        gate_timeout_s = 1'b0;
        car_entered_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (tailgate_s) alarm_2_s = 1'b1;
                else            alarm_2_s = alarm_2_r;
            end
            PIN: begin
                if (tailgate_s) begin
                    alarm_2_s = 1'b1;
                end else if (try_ok_s) begin
                    fail_count_s = '0;
                    alarm_1_s    = 1'b0;
                    open_gate_s  = 1'b1;
                end else if (try_bad_s) begin
                    fail_count_s = fail_inc_s;
                    alarm_1_s    = alarm_1_r || (fail_inc_s == FC_MAX);
                end else begin
                    fail_count_s = fail_count_r;
                end
            end
            OPEN: begin
                if (tailgate_s) begin
                    alarm_2_s    = 1'b1;
                    open_gate_s  = 1'b0;
                    close_gate_s = 1'b1;
                end else if (sensor_2) begin
                    open_gate_s   = 1'b0;
                    close_gate_s  = 1'b1;
                    car_entered_s = 1'b1;
                end else if (timeout_hit_s) begin
                    open_gate_s    = 1'b0;
                    close_gate_s   = 1'b1;
                    gate_timeout_s = 1'b1;
                end else begin
                    open_gate_s = open_gate_r;
                end
            end
            BLOCK: begin
                open_gate_s = 1'b0;
                if (try_ok_s) begin
                    alarm_2_s    = 1'b0;
                    alarm_1_s    = 1'b0;
                    fail_count_s = '0;
                end else begin
                    alarm_2_s = alarm_2_r;
                end
            end
            default: open_gate_s = 1'b0;
        endcase
    end

`ifdef PARK_OCCUPANCY_EN
    parking_occupancy_counter #(
        .CAPACITY (CAPACITY)
    ) u_occupancy (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc       (car_entered_s),
        .dec       (car_exit),
        .occupancy (occupancy_s),
        .full      (lot_full_s)
    );
`else
    logic unused_s;
    assign unused_s    = car_exit ^ car_entered_s;
    assign occupancy_s = '0;
    assign lot_full_s  = 1'b0;
`endif

    assign alarm_1      = alarm_1_r;
    assign alarm_2      = alarm_2_r;
    assign open_gate    = open_gate_r;
    assign close_gate   = close_gate_r;
    assign gate_timeout = gate_timeout_r;
    assign fail_count   = fail_count_r;
    assign occupancy    = occupancy_s;
    assign lot_full     = lot_full_s;

endmodule
